s15850_n485_scan_drv: RTL and testbench
=======================================

// Module: s15850_n485_scan_drv
// PURPOSE
//  Scan-style stimulus driver and response collector for the s15850 n485 combinational cone.
//  - Accepts a 21-bit test vector serially and presents it in parallel on the cone's inputs.
//  - Captures the cone's single output bit and returns it serially.
//  - Sits between the tester/BIST serial link and the cone instance; it is the write/apply side of the cone.
// PARAMETERS
//  VEC_W   21   pattern width (number of cone inputs)
//  CNT_W    5   shift-counter width; must satisfy 2**CNT_W > VEC_W
//  SIG_W   16   MISR width (used only with SCAN_MISR_EN)
// PORTS
//  CK        in   1      clock, all state rising-edge
//  RST       in   1      synchronous reset, active-high
//  start     in   1      begin one load/apply/capture/unload pass (sampled in IDLE only)
//  si        in   1      serial pattern bit
//  si_valid  in   1      si qualifier; one bit accepted per cycle while in SHIFT
//  vec_out   out  VEC_W  parallel pattern; bit20=g599,19=g591,18=g605,17=g611,16=g713,15=g617,
//                        14=g731,13=g718,12=g722,11=g627,10=g639,9=g654,8=g646,7=g650,6=g643,
//                        5=g695,4=g704,3=g677,2=g686,1=g668,0=g658
//  resp_in   in   1      cone output n485
//  so        out  1      captured response bit
//  so_valid  out  1      so qualifier, one-cycle pulse
//  busy      out  1      high in every state except IDLE
//  done      out  1      one-cycle pulse when the pass completes
//  sig       out  SIG_W  MISR signature (present only with SCAN_MISR_EN)
//  sig_clr   in   1      clear MISR (present only with SCAN_MISR_EN)
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; counter=0; vec_out=0.
//  FSM: IDLE -> SHIFT -> APPLY -> CAPTURE -> UNLOAD -> IDLE.
//   - IDLE: start=1 -> SHIFT next cycle, counter cleared.
//   - SHIFT: each cycle with si_valid=1: vec_out <= {vec_out[VEC_W-2:0], si}, counter+1.
//     si_valid=0 stalls (no shift, no count).
//     The VEC_W-th accepted bit moves to APPLY. First bit sent ends at bit20 (MSB-first).
//   - APPLY: one settle cycle; vec_out held.
//   - CAPTURE: resp_in registered into the capture flop.
//   - UNLOAD: so = captured bit, so_valid=1, done=1 (same cycle); next state IDLE.
//  Latency: last accepted si -> so_valid/done = 3 cycles.
//  vec_out holds its last pattern after the pass; it changes only in SHIFT or on RST.
//  start outside IDLE is ignored. si_valid outside SHIFT is ignored.
//  Counter never wraps: the exit compare is on count==VEC_W-1 with si_valid.
//  RST at any state forces the reset values next cycle; a partial pattern is discarded.
//  Back-to-back passes: start asserted in the cycle after done is accepted (IDLE lasts >= 1 cycle).
// CONFIGURATION
//  SCAN_MISR_EN defined:
//   - SIG_W-bit MISR, polynomial 0x1021 (x^16+x^12+x^5+1).
//   - Updated in CAPTURE: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, resp_in}.
//   - sig_clr=1 zeroes sig next cycle; sig_clr has priority over a CAPTURE update.
//   - RST also zeroes sig.
//  SCAN_MISR_EN undefined: sig and sig_clr ports absent, no MISR logic; serial response path unchanged.
// STRUCTURE
//  Shared package s15850_scan_pkg holds:
//   - state enum scan_st_t {IDLE, SHIFT, APPLY, CAPTURE, UNLOAD};
//   - VEC_W, CNT_W, SIG_W;
//   - MISR_POLY = 16'h1021.
//  One sub-module, s15850_scan_misr (MISR register plus update logic), instantiated under SCAN_MISR_EN.
//  The cone is instantiated by the bench/top, not inside this block.
// TESTING
//  1. RST held 3 cycles mid-SHIFT (10 bits loaded)
//     -> all outputs 0, state IDLE; a following full pass behaves normally.
//  2. start, 21 zero bits with si_valid=1 continuous
//     -> vec_out=21'h0 (cone: g591=g599=g605=g611=0 gives n485=0); so_valid with so=0 exactly 3 cycles after the last bit; done same cycle.
//  3. Pattern 21'h1FFFFF sent with si_valid toggling 1/0
//     -> exactly 21 shifts, vec_out=21'h1FFFFF; so equals the cone reference-model value.
//  4. Pattern 21'h100000 (g599 only)
//     -> first bit lands at vec_out[20]; bench checks so against the reference model.
//  5. start pulsed during SHIFT and during UNLOAD
//     -> ignored; no extra pass; busy drops for >= 1 cycle between passes.
//  6. SCAN_MISR_EN: sig_clr, then passes with responses 1,0,1
//     -> sig=16'h0005; sig_clr asserted in a CAPTURE cycle -> sig=0.

Source files
------------

// File: rtl/s15850_scan_pkg.sv
// rtl/s15850_scan_pkg.sv - shared widths, MISR polynomial and FSM states for the s15850 scan driver
package s15850_scan_pkg;

  localparam int VEC_W = 21;
  localparam int CNT_W = 5;
  localparam int SIG_W = 16;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    APPLY,
    CAPTURE,
    UNLOAD
  } scan_st_t;

endpackage

// File: rtl/s15850_scan_misr.sv
// rtl/s15850_scan_misr.sv - response-compacting MISR (x^16+x^12+x^5+1), folded in one bit per capture
module s15850_scan_misr
  import s15850_scan_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic             din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Clear wins over an update landing in the same cycle.
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (upd_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, din_i};
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/s15850_n485_scan_drv.sv
// rtl/s15850_n485_scan_drv.sv - serial load/apply/capture/unload driver for the n485 cone; SCAN_MISR_EN adds a signature MISR
module s15850_n485_scan_drv
  import s15850_scan_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             si,
  input  logic             si_valid,
  output logic [VEC_W-1:0] vec_out,
  input  logic             resp_in,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
`ifdef SCAN_MISR_EN
  ,
  output logic [SIG_W-1:0] sig,
  input  logic             sig_clr
`endif
);

  scan_st_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             cap_q, cap_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    cap_d    = cap_q;
    so       = 1'b0;
    so_valid = 1'b0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // MSB-first: the first accepted bit ends up in vec_out[VEC_W-1].
        if (si_valid) begin
          vec_d = {vec_q[VEC_W-2:0], si};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(VEC_W - 1)) begin
            state_d = APPLY;
          end
        end
      end
      APPLY: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        cap_d   = resp_in;
        state_d = UNLOAD;
      end
      UNLOAD: begin
        so       = cap_q;
        so_valid = 1'b1;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      cap_q   <= cap_d;
    end
  end

  assign vec_out = vec_q;

`ifdef SCAN_MISR_EN
  s15850_scan_misr u_misr (
    .CK    (CK),
    .RST   (RST),
    .clr_i (sig_clr),
    .upd_i (state_q == CAPTURE),
    .din_i (resp_in),
    .sig_o (sig)
  );
`endif

endmodule

// File: tb/tb_s15850_n485_scan_drv.sv
// tb/tb_s15850_n485_scan_drv.sv - directed self-checking bench for s15850_n485_scan_drv (MISR checks under SCAN_MISR_EN)
module tb_s15850_n485_scan_drv;

  logic        CK = 1'b0;
  logic        RST;
  logic        start;
  logic        si;
  logic        si_valid;
  logic [20:0] vec_out;
  logic        resp_in;
  logic        so;
  logic        so_valid;
  logic        busy;
  logic        done;
`ifdef SCAN_MISR_EN
  logic [15:0] sig;
  logic        sig_clr;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [20:0] model_vec;

  always #5 CK = ~CK;

  // Stand-in cone: zero whenever g599=g591=g605=g611=0.
  function automatic logic cone(input logic [20:0] v);
    return (v[20] ^ v[19]) | (v[18] & v[17] & v[16]);
  endfunction

  assign resp_in = cone(vec_out);

  s15850_n485_scan_drv dut (
    .CK       (CK),
    .RST      (RST),
    .start    (start),
    .si       (si),
    .si_valid (si_valid),
    .vec_out  (vec_out),
    .resp_in  (resp_in),
    .so       (so),
    .so_valid (so_valid),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_MISR_EN
    ,
    .sig      (sig),
    .sig_clr  (sig_clr)
`endif
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input logic [20:0] pat, input bit toggle, input bit start_glitch,
                          input bit clr_cap);
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_in_shift", busy, 1);
    for (int i = 20; i >= 0; i--) begin
      si       = pat[i];
      si_valid = 1'b1;
      if (start_glitch && i == 15) start = 1'b1;
      tick();
      start     = 1'b0;
      model_vec = {model_vec[19:0], pat[i]};
      check("shift_vec", vec_out, model_vec);
      if (toggle && i > 0) begin
        si_valid = 1'b0;
        si       = ~pat[i];
        tick();
        check("stall_vec", vec_out, model_vec);
      end
    end
    si_valid = 1'b0;
    si       = 1'b0;
    lat      = 1;
    while (!so_valid && lat < 10) begin
`ifdef SCAN_MISR_EN
      if (clr_cap && lat == 2) sig_clr = 1'b1;
`endif
      tick();
`ifdef SCAN_MISR_EN
      sig_clr = 1'b0;
`endif
      lat++;
    end
    check("latency", lat, 3);
    check("so", so, cone(pat));
    check("done_pulse", done, 1);
    check("vec_applied", vec_out, pat);
`ifdef SCAN_MISR_EN
    if (clr_cap) check("sig_clr_in_capture", sig, 0);
`endif
    if (start_glitch) start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_so_valid", so_valid, 0);
    tick();
    check("stay_idle", busy, 0);
    check("vec_hold", vec_out, pat);
  endtask

  initial begin
    RST      = 1'b1;
    start    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
`ifdef SCAN_MISR_EN
    sig_clr  = 1'b0;
`endif
    model_vec = '0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_vec", vec_out, 0);
    check("rst_busy", busy, 0);
    check("rst_so", so, 0);
    check("rst_so_valid", so_valid, 0);
    check("rst_done", done, 0);

    // Reset in the middle of a load discards the partial pattern.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      si       = 1'b1;
      si_valid = 1'b1;
      tick();
    end
    check("partial_vec", vec_out, 21'h0003FF);
    RST = 1'b1;
    tick();
    tick();
    tick();
    si_valid = 1'b0;
    si       = 1'b0;
    check("midrst_vec", vec_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_so_valid", so_valid, 0);
    check("midrst_done", done, 0);
    RST       = 1'b0;
    model_vec = '0;
    tick();
    check("post_rst_idle", busy, 0);

`ifdef SCAN_MISR_EN
    check("sig_rst", sig, 0);
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    check("sig_clr", sig, 0);
`endif

    run_pass(21'h1FFFFF, 1'b1, 1'b0, 1'b0);
    run_pass(21'h000000, 1'b0, 1'b0, 1'b0);
    run_pass(21'h100000, 1'b0, 1'b1, 1'b0);
    check("msb_first", vec_out[20], 1);
`ifdef SCAN_MISR_EN
    check("sig_101", sig, 16'h0005);
`endif
    run_pass(21'h0ABCDE, 1'b0, 1'b0, 1'b1);
`ifdef SCAN_MISR_EN
    check("sig_after_clr", sig, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
